bp_be_late_wb_queue: RTL

- Parametrised, multi-entry successor to the single-slot late-writeback path of the memory pipe.
- Tracks up to els_p committed non-blocking loads (int, float, PTW) that missed in the D$.
- Accepts fill data returned out of order, tagged by request id.
- Retires writebacks to the register files strictly in allocation order. Sits between the D$ engine return path and the late writeback port of the calculator.

---
 rtl/bp_be_pkg.sv | 21 ++
 rtl/bp_be_late_wb_cam.sv | 22 ++
 rtl/bp_be_late_wb_queue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// rtl/bp_be_pkg.sv - shared types for the backend late-writeback queue
package bp_be_pkg;

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } bp_be_late_wb_state_e;

  // Destination register-file class of a late load; exactly one bit is set.
  typedef struct packed {
    logic int_v;
    logic float_v;
    logic ptw_v;
  } bp_be_late_wb_class_s;

  function automatic logic late_wb_class_onehot(input bp_be_late_wb_class_s c);
    return (c.int_v + c.float_v + c.ptw_v) == 2'd1;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_cam.sv
// rtl/bp_be_late_wb_cam.sv - associative tag compare across the late-writeback entries
module bp_be_late_wb_cam #(
  parameter int els_p       = 4,
  parameter int tag_width_p = 2
) (
  input  logic [els_p-1:0][tag_width_p-1:0] tags_i,
  input  logic [els_p-1:0]                  v_i,
  input  logic [tag_width_p-1:0]            key_i,
  output logic [els_p-1:0]                  match_oh_o,
  output logic                              any_match_o
);

  always_comb begin
    match_oh_o = '0;
    for (int i = 0; i < els_p; i++) begin
      match_oh_o[i] = v_i[i] & (tags_i[i] == key_i);
    end
  end

  assign any_match_o = |match_oh_o;

endmodule

// File: rtl/bp_be_late_wb_queue.sv
// rtl/bp_be_late_wb_queue.sv - in-order retirement queue for out-of-order D$ miss fills
module bp_be_late_wb_queue
  import bp_be_pkg::*;
#(
  parameter int els_p            = 4,
  parameter int id_width_p       = 2,
  parameter int data_width_p     = 66,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic                        alloc_v_i,
  output logic                        alloc_ready_o,
  input  logic [id_width_p-1:0]       alloc_id_i,
  input  logic [reg_addr_width_p-1:0] alloc_rd_addr_i,
  input  logic                        alloc_int_i,
  input  logic                        alloc_float_i,
  input  logic                        alloc_ptw_i,

  input  logic                        fill_v_i,
  input  logic [id_width_p-1:0]       fill_id_i,
  input  logic [data_width_p-1:0]     fill_data_i,
  output logic                        fill_err_o,

  output logic                        wb_v_o,
  input  logic                        wb_yumi_i,
  output logic                        wb_int_o,
  output logic                        wb_float_o,
  output logic                        wb_ptw_o,
  output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
  output logic [data_width_p-1:0]     wb_data_o,

  input  logic [reg_addr_width_p-1:0] probe_rd_addr_i,
  input  logic                        probe_float_i,
  output logic                        probe_hit_o,

  output logic                        empty_o
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam int probe_tag_width_lp = reg_addr_width_p + 1;

  typedef struct packed {
    logic [id_width_p-1:0]       id;
    logic [reg_addr_width_p-1:0] rd;
    bp_be_late_wb_class_s        cls;
    logic [data_width_p-1:0]     data;
  } late_wb_entry_s;

  bp_be_late_wb_state_e    state_r [els_p];
  late_wb_entry_s          entry_r [els_p];
  logic [ptr_width_lp-1:0] head_r, tail_r;
  logic [cnt_width_lp-1:0] count_r;
  logic                    fill_err_r;

  logic alloc_accept, wb_pop, full;

  logic [els_p-1:0][id_width_p-1:0]         fill_tags;
  logic [els_p-1:0]                         wait_v;
  logic [els_p-1:0]                         fill_match_oh;
  logic                                     fill_any;
  logic [els_p-1:0][probe_tag_width_lp-1:0] probe_tags;
  logic [els_p-1:0]                         probe_v;
  logic [els_p-1:0]                         probe_match_oh;
  logic                                     probe_any;

  bp_be_late_wb_class_s alloc_cls;
  assign alloc_cls = '{int_v: alloc_int_i, float_v: alloc_float_i, ptw_v: alloc_ptw_i};

  // Ready is derived from the registered count only, so a pop never bypasses into alloc.
  assign full          = (count_r == cnt_width_lp'(els_p));
  assign alloc_ready_o = ~full;
  assign empty_o       = (count_r == '0);
  assign alloc_accept  = alloc_v_i & alloc_ready_o;
  assign wb_pop        = wb_yumi_i & wb_v_o;

  // Int probes of x0 and all PTW entries are masked out before the compare.
  always_comb begin
    fill_tags  = '0;
    wait_v     = '0;
    probe_tags = '0;
    probe_v    = '0;
    for (int i = 0; i < els_p; i++) begin
      fill_tags[i]  = entry_r[i].id;
      wait_v[i]     = (state_r[i] == WAIT);
      probe_tags[i] = {entry_r[i].rd, entry_r[i].cls.float_v};
      probe_v[i]    = (state_r[i] != FREE) & ~entry_r[i].cls.ptw_v
                    & ~(entry_r[i].cls.int_v & (entry_r[i].rd == '0));
    end
  end

  bp_be_late_wb_cam #(
    .els_p       (els_p),
    .tag_width_p (id_width_p)
  ) fill_cam (
    .tags_i      (fill_tags),
    .v_i         (wait_v),
    .key_i       (fill_id_i),
    .match_oh_o  (fill_match_oh),
    .any_match_o (fill_any)
  );

  bp_be_late_wb_cam #(
    .els_p       (els_p),
    .tag_width_p (probe_tag_width_lp)
  ) probe_cam (
    .tags_i      (probe_tags),
    .v_i         (probe_v),
    .key_i       ({probe_rd_addr_i, probe_float_i}),
    .match_oh_o  (probe_match_oh),
    .any_match_o (probe_any)
  );

  assign probe_hit_o = probe_any;

  // Alloc targets a FREE slot, fill a WAIT slot, pop a READY slot: the three never collide.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        state_r[i] <= FREE;
      end
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      fill_err_r <= 1'b0;
    end else begin
      fill_err_r <= fill_v_i & ~fill_any;
      if (alloc_accept) begin
        state_r[tail_r] <= WAIT;
        tail_r          <= tail_r + 1'b1;
      end
      for (int i = 0; i < els_p; i++) begin
        if (fill_v_i && fill_match_oh[i]) begin
          state_r[i] <= READY;
        end
      end
      if (wb_pop) begin
        state_r[head_r] <= FREE;
        head_r          <= head_r + 1'b1;
      end
      count_r <= count_r + cnt_width_lp'(alloc_accept) - cnt_width_lp'(wb_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (alloc_accept) begin
      entry_r[tail_r].id  <= alloc_id_i;
      entry_r[tail_r].rd  <= alloc_rd_addr_i;
      entry_r[tail_r].cls <= alloc_cls;
    end
    for (int i = 0; i < els_p; i++) begin
      if (fill_v_i && fill_match_oh[i]) begin
        entry_r[i].data <= fill_data_i;
      end
    end
  end

  assign fill_err_o   = fill_err_r;
  assign wb_v_o       = (state_r[head_r] == READY);
  assign wb_int_o     = entry_r[head_r].cls.int_v;
  assign wb_float_o   = entry_r[head_r].cls.float_v;
  assign wb_ptw_o     = entry_r[head_r].cls.ptw_v;
  assign wb_rd_addr_o = entry_r[head_r].rd;
  assign wb_data_o    = entry_r[head_r].data;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!wb_yumi_i || wb_v_o);
      if (alloc_v_i) assert (late_wb_class_onehot(alloc_cls));
      assert (!(alloc_accept && full));
      for (int i = 0; i < els_p; i++) begin
        if (alloc_accept && state_r[i] != FREE) assert (entry_r[i].id != alloc_id_i);
        assert (!(probe_match_oh[i] && entry_r[i].cls.ptw_v));
      end
    end
  end

endmodule
